// File: rtl/syscall_sequencer_pkg.sv
// rtl/syscall_sequencer_pkg.sv - syscall codes and sequencer state encoding
package syscall_sequencer_pkg;

    localparam logic [31:0] SC_PRINT_INT  = 32'd1;
    localparam logic [31:0] SC_PRINT_STR  = 32'd4;
    localparam logic [31:0] SC_EXIT       = 32'd10;
    localparam logic [31:0] SC_PRINT_CHAR = 32'd11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_EMIT_INT,
        ST_EMIT_CHAR,
        ST_STR_FETCH,
        ST_STR_BYTE,
        ST_STR_EMIT,
        ST_HALT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/syscall_sequencer_byte_select.sv
// rtl/syscall_sequencer_byte_select.sv - big-endian byte extraction from a 32-bit word
module byte_select (
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    output logic [7:0]  sel_byte
);

    always_comb begin
        sel_byte = 8'h00;
        case (offset)
            2'd0: sel_byte = word[31:24];
            2'd1: sel_byte = word[23:16];
            2'd2: sel_byte = word[15:8];
            2'd3: sel_byte = word[7:0];
            default: sel_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/syscall_sequencer.sv
// rtl/syscall_sequencer.sv - multi-cycle SYSCALL executor: stalls pipeline, reads strings, drives console
module syscall_sequencer
    import syscall_sequencer_pkg::*;
#(
    parameter int MAX_STR_LEN = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              syscall_valid,
    input  logic [31:0]       v0,
    input  logic [31:0]       a0,
    output logic              stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    output logic              out_is_int,
    output logic [31:0]       out_data,
    input  logic              out_ready,
    output logic              halted,
    output logic              sc_error
);

    localparam int CNT_W = $clog2(MAX_STR_LEN + 1);

    state_t             state;
    logic [31:0]        code_q;
    logic [31:0]        a0_q;
    logic [ADDR_W-1:0]  ptr;
    logic [ADDR_W-1:0]  ptr_next;
    logic [31:0]        word_buf;
    logic               buf_valid;
    logic [CNT_W-1:0]   count;
    logic               rearm_q;
    logic [7:0]         cur_byte;

    byte_select u_byte_select (
        .word     (word_buf),
        .offset   (ptr[1:0]),
        .sel_byte (cur_byte)
    );

    assign ptr_next = ptr + ADDR_W'(1);

    // rearm_q masks the still-presented SYSCALL for the one IDLE cycle after DONE
    assign stall = (state != ST_IDLE) || halted || (syscall_valid && !rearm_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            code_q     <= '0;
            a0_q       <= '0;
            ptr        <= '0;
            word_buf   <= '0;
            buf_valid  <= 1'b0;
            count      <= '0;
            rearm_q    <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            out_valid  <= 1'b0;
            out_is_int <= 1'b0;
            out_data   <= '0;
            halted     <= 1'b0;
            sc_error   <= 1'b0;
        end else begin
            sc_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    rearm_q <= 1'b0;
                    if (syscall_valid && !rearm_q) begin
                        code_q <= v0;
                        a0_q   <= a0;
                        ptr    <= a0[ADDR_W-1:0];
                        count  <= '0;
                        state  <= ST_DISPATCH;
                    end
                end
                ST_DISPATCH: begin
                    case (code_q)
                        SC_PRINT_INT: begin
                            out_valid  <= 1'b1;
                            out_is_int <= 1'b1;
                            out_data   <= a0_q;
                            state      <= ST_EMIT_INT;
                        end
                        SC_PRINT_CHAR: begin
                            out_valid  <= 1'b1;
                            out_is_int <= 1'b0;
                            out_data   <= {24'b0, a0_q[7:0]};
                            state      <= ST_EMIT_CHAR;
                        end
                        SC_PRINT_STR: begin
                            buf_valid <= 1'b0;
                            mem_req   <= 1'b1;
                            mem_addr  <= {ptr[ADDR_W-1:2], 2'b00};
                            state     <= ST_STR_FETCH;
                        end
                        SC_EXIT: begin
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end
                        default: begin
                            sc_error <= 1'b1;
                            state    <= ST_DONE;
                        end
                    endcase
                end
                ST_EMIT_INT, ST_EMIT_CHAR: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        out_is_int <= 1'b0;
                        state      <= ST_DONE;
                    end
                end
                ST_STR_FETCH: begin
                    if (mem_ack) begin
                        word_buf  <= mem_rdata;
                        buf_valid <= 1'b1;
                        mem_req   <= 1'b0;
                        state     <= ST_STR_BYTE;
                    end
                end
                ST_STR_BYTE: begin
                    if (!buf_valid) begin
                        mem_req  <= 1'b1;
                        mem_addr <= {ptr[ADDR_W-1:2], 2'b00};
                        state    <= ST_STR_FETCH;
                    end else if (cur_byte == 8'h00) begin
                        state <= ST_DONE;
                    end else if (count == CNT_W'(MAX_STR_LEN)) begin
                        sc_error <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        out_valid  <= 1'b1;
                        out_is_int <= 1'b0;
                        out_data   <= {24'b0, cur_byte};
                        state      <= ST_STR_EMIT;
                    end
                end
                ST_STR_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ptr       <= ptr_next;
                        count     <= count + CNT_W'(1);
                        if (ptr[1:0] == 2'd3) begin
                            buf_valid <= 1'b0;
                            mem_req   <= 1'b1;
                            mem_addr  <= {ptr_next[ADDR_W-1:2], 2'b00};
                            state     <= ST_STR_FETCH;
                        end else begin
                            state <= ST_STR_BYTE;
                        end
                    end
                end
                ST_HALT: state <= ST_HALT;
                ST_DONE: begin
                    rearm_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_sequencer.sv
// tb/tb_syscall_sequencer.sv - directed self-checking bench for syscall_sequencer
module tb_syscall_sequencer;

    logic        clk;
    logic        reset;
    logic        syscall_valid;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_is_int;
    logic [31:0] out_data;
    logic        out_ready;
    logic        halted;
    logic        sc_error;

    syscall_sequencer #(.MAX_STR_LEN(4), .ADDR_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .syscall_valid (syscall_valid),
        .v0            (v0),
        .a0            (a0),
        .stall         (stall),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_is_int    (out_is_int),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .halted        (halted),
        .sc_error      (sc_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] q_data [$];
    logic        q_int [$];
    logic [31:0] req_q [$];
    logic [7:0]  exp_chars [$];
    int stall_cnt, err_cnt, addr_glitch, data_glitch;
    int ack_delay   = 0;
    int ready_delay = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] addr);
        return mem.exists(addr) ? mem[addr] : 32'h0;
    endfunction

    // memory responder: acks after ack_delay waiting cycles, watches address stability
    initial begin
        int mw;
        logic [31:0] maddr;
        mw = 0;
        maddr = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset || mem_ack) begin
                mem_ack = 1'b0;
                mw = 0;
            end else if (mem_req) begin
                if (mw == 0) maddr = mem_addr;
                else if (mem_addr !== maddr) addr_glitch++;
                if (mw == ack_delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_read(mem_addr);
                    req_q.push_back(mem_addr);
                    mw = 0;
                end else begin
                    mw++;
                end
            end
        end
    end

    // console sink: holds out_ready low ready_delay cycles per item
    initial begin
        int rw;
        logic [31:0] odat;
        rw = 0;
        odat = '0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_delay == 0) begin
                out_ready = 1'b1;
            end else if (out_valid) begin
                if (rw == 0) odat = out_data;
                else if (out_data !== odat) data_glitch++;
                if (rw == ready_delay) begin
                    out_ready = 1'b1;
                    rw = 0;
                end else begin
                    out_ready = 1'b0;
                    rw++;
                end
            end else begin
                out_ready = 1'b0;
                rw = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (stall) stall_cnt++;
            if (sc_error) err_cnt++;
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_int.push_back(out_is_int);
            end
        end
    end

    task automatic clear_obs();
        q_data.delete();
        q_int.delete();
        req_q.delete();
        stall_cnt = 0;
        err_cnt = 0;
        addr_glitch = 0;
        data_glitch = 0;
    endtask

    task automatic start_syscall(input logic [31:0] code, input logic [31:0] arg, input int hold);
        clear_obs();
        @(posedge clk);
        #1;
        v0 = code;
        a0 = arg;
        syscall_valid = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        syscall_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && stall; i++) @(negedge clk);
        #1;
        check_eq({tag, "_stall_release"}, {31'b0, stall}, 32'd0);
    endtask

    task automatic check_chars(input string tag);
        check_eq({tag, "_beats"}, q_data.size(), exp_chars.size());
        for (int i = 0; i < q_data.size() && i < exp_chars.size(); i++) begin
            check_eq($sformatf("%s_char%0d", tag, i), q_data[i], {24'b0, exp_chars[i]});
            check_eq($sformatf("%s_isint%0d", tag, i), {31'b0, q_int[i]}, 32'd0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_stall"},    {31'b0, stall},      32'd0);
        check_eq({tag, "_mem_req"},  {31'b0, mem_req},    32'd0);
        check_eq({tag, "_mem_addr"}, mem_addr,            32'd0);
        check_eq({tag, "_valid"},    {31'b0, out_valid},  32'd0);
        check_eq({tag, "_is_int"},   {31'b0, out_is_int}, 32'd0);
        check_eq({tag, "_data"},     out_data,            32'd0);
        check_eq({tag, "_halted"},   {31'b0, halted},     32'd0);
        check_eq({tag, "_sc_error"}, {31'b0, sc_error},   32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        syscall_valid = 1'b0;
        v0 = '0;
        a0 = '0;
        mem[32'h100] = 32'h48690A00;
        mem[32'h200] = 32'h31323334;
        mem[32'h204] = 32'h35363738;
        clear_obs();
        repeat (2) @(posedge clk);
        #2;
        check_idle_outputs("reset");
        reset = 1'b0;

        // print_int
        start_syscall(32'd1, 32'hFFFFFFFE, 1);
        wait_idle("int");
        check_eq("int_beats", q_data.size(), 32'd1);
        check_eq("int_data", (q_data.size() > 0) ? q_data[0] : 32'hDEADBEEF, 32'hFFFFFFFE);
        check_eq("int_is_int", (q_int.size() > 0) ? {31'b0, q_int[0]} : 32'd0, 32'd1);
        check_eq("int_stall_cycles", stall_cnt, 32'd4);

        // print_char with SYSCALL held through the post-DONE IDLE cycle
        start_syscall(32'd11, 32'h12345641, 5);
        wait_idle("char");
        exp_chars = '{8'h41};
        check_chars("char");
        check_eq("char_stall_cycles", stall_cnt, 32'd4);

        // print_string aligned
        start_syscall(32'd4, 32'h100, 1);
        wait_idle("str_al");
        exp_chars = '{8'h48, 8'h69, 8'h0A};
        check_chars("str_al");
        check_eq("str_al_reqs", req_q.size(), 32'd1);
        check_eq("str_al_addr0", (req_q.size() > 0) ? req_q[0] : 32'hDEADBEEF, 32'h100);
        check_eq("str_al_err", err_cnt, 32'd0);

        // print_string unaligned crossing a word
        mem[32'h100] = 32'h12344142;
        mem[32'h104] = 32'h43000000;
        start_syscall(32'd4, 32'h102, 1);
        wait_idle("str_un");
        exp_chars = '{8'h41, 8'h42, 8'h43};
        check_chars("str_un");
        check_eq("str_un_reqs", req_q.size(), 32'd2);
        check_eq("str_un_addr0", (req_q.size() > 0) ? req_q[0] : 32'hDEADBEEF, 32'h100);
        check_eq("str_un_addr1", (req_q.size() > 1) ? req_q[1] : 32'hDEADBEEF, 32'h104);

        // backpressure on both memory and console
        ack_delay = 3;
        ready_delay = 5;
        start_syscall(32'd4, 32'h102, 1);
        wait_idle("bp");
        check_chars("bp");
        check_eq("bp_reqs", req_q.size(), 32'd2);
        check_eq("bp_addr_stable", addr_glitch, 32'd0);
        check_eq("bp_data_stable", data_glitch, 32'd0);
        ack_delay = 0;
        ready_delay = 0;

        // unknown code
        start_syscall(32'd7, 32'h0, 1);
        wait_idle("unk");
        check_eq("unk_beats", q_data.size(), 32'd0);
        check_eq("unk_err_pulses", err_cnt, 32'd1);
        check_eq("unk_halted", {31'b0, halted}, 32'd0);

        // string longer than MAX_STR_LEN=4 with no terminator
        start_syscall(32'd4, 32'h200, 1);
        wait_idle("max");
        exp_chars = '{8'h31, 8'h32, 8'h33, 8'h34};
        check_chars("max");
        check_eq("max_err_pulses", err_cnt, 32'd1);

        // reset while a string character waits for acceptance
        ready_delay = 5;
        start_syscall(32'd4, 32'h200, 1);
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        check_eq("mid_out_valid", {31'b0, out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        ready_delay = 0;

        // exit: halted and stall persist until reset
        start_syscall(32'd10, 32'h0, 1);
        repeat (12) @(negedge clk);
        check_eq("exit_halted", {31'b0, halted}, 32'd1);
        check_eq("exit_stall", {31'b0, stall}, 32'd1);
        check_eq("exit_beats", q_data.size(), 32'd0);
        do_reset();
        #2;
        check_idle_outputs("post_exit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/syscall_sequencer.md
Name: syscall_sequencer

Overview:
- Multi-cycle controller that executes SYSCALL for the pipelined MIPS core.
- It is triggered by the decoder's syscall indication in the EX stage.
- While it runs it stalls the pipeline, walks memory through a read port shared with the data-memory arbiter, and streams characters or integers to the console interface.
- Services print_int ($v0=1), print_string ($v0=4), exit ($v0=10) and print_char ($v0=11).

Parameters:
- MAX_STR_LEN, 1024: maximum characters emitted per print_string before forced termination with an error.
- ADDR_W, 32: memory byte-address width.

Ports:
- clk  in  1  core clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- syscall_valid  in  1  EX-stage instruction is SYSCALL (decoded syscall_control, qualified by not-flushed)
- v0  in  32  forwarded $v0 value, valid with syscall_valid
- a0  in  32  forwarded $a0 value, valid with syscall_valid
- stall  out  1  freeze IF/ID/EX, bubble MEM
- mem_req  out  1  read request to the data-memory arbiter
- mem_addr  out  ADDR_W  word-aligned read address
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  32  read word, big-endian
- out_valid  out  1  console output item valid
- out_is_int  out  1  1 = out_data is a 32-bit integer, 0 = out_data[7:0] is a character
- out_data  out  32  output item
- out_ready  in  1  console accepts the item
- halted  out  1  exit executed (sticky)
- sc_error  out  1  one-cycle pulse: unknown code, or string exceeded MAX_STR_LEN

Behaviour:
- Reset (async, any state): FSM to IDLE.
  - stall, mem_req, out_valid, out_is_int, halted, sc_error = 0.
  - mem_addr, out_data = 0.
  - Word buffer invalidated.
- stall is combinational: (state != IDLE) OR (state == IDLE AND syscall_valid) OR halted.
  - The pipeline therefore freezes in the same cycle the SYSCALL is seen.
  - stall is deasserted in the cycle after DONE.
- States:
  - IDLE: on syscall_valid, latch code = v0 and ptr = a0, then go to DISPATCH.
  - DISPATCH: routes on the latched code.
    - 1 -> EMIT_INT
    - 11 -> EMIT_CHAR
    - 4 -> STR_FETCH
    - 10 -> HALT
    - any other code -> pulse sc_error, go to DONE
  - EMIT_INT: out_valid=1, out_is_int=1, out_data=a0 latch; on out_ready go to DONE.
  - EMIT_CHAR: out_valid=1, out_is_int=0, out_data={24'b0, a0[7:0]}; on out_ready go to DONE.
  - STR_FETCH: mem_req=1, mem_addr={ptr[31:2],2'b00}.
    - mem_req and mem_addr are held stable until mem_ack.
    - On mem_ack, capture mem_rdata into the word buffer, set it valid, go to STR_BYTE.
  - STR_BYTE: select byte by ptr[1:0] (big-endian: 0 -> [31:24], 3 -> [7:0]).
    - Byte == 0x00: go to DONE; no output is emitted for the null.
    - Count == MAX_STR_LEN: pulse sc_error, go to DONE.
    - Otherwise: present the byte, out_valid=1, go to STR_EMIT.
  - STR_EMIT: hold out_valid, out_data stable until out_ready. On acceptance:
    - ptr <= ptr+1 (wraps mod 2^ADDR_W); count++.
    - If ptr[1:0] was 3, invalidate the buffer and go to STR_FETCH; else go to STR_BYTE.
  - HALT: halted=1 forever, stall=1 forever; only reset exits.
  - DONE: one cycle, stall still 1; then go to IDLE.
- Latency:
  - print_int / print_char with out_ready=1: syscall_valid seen -> DONE after 3 cycles; stall high for 4 cycles.
  - print_string: one memory transaction per 4 characters. A string starting at an unaligned address fetches its first word once and uses bytes ptr[1:0]..3.
- syscall_valid while not IDLE is ignored; the pipeline is stalled, so the same instruction stays presented.
- In the IDLE cycle that follows DONE, syscall_valid is ignored for one cycle. This prevents the just-completed SYSCALL from re-triggering before EX advances.
- mem_ack without mem_req is ignored.
- out_valid never drops without out_ready.

Decomposition:
- Shared package/header (mips.h): syscall code constants SC_PRINT_INT=1, SC_PRINT_STR=4, SC_EXIT=10, SC_PRINT_CHAR=11; FSM state encoding constants.
- One natural sub-module, byte_select: combinational 32-bit word + 2-bit offset -> 8-bit big-endian byte, reusable by the LB path.
- Everything else stays in syscall_sequencer.

Test Plan:
- print_int: v0=1, a0=0xFFFFFFFE, out_ready=1 -> one out_valid beat, out_is_int=1, out_data=0xFFFFFFFE; stall high exactly 4 cycles.
- print_string aligned: v0=4, a0=0x100, mem[0x100]=0x48690A00 -> emits 'H','i','\n'; exactly one mem_req to 0x100; stall drops after the null.
- print_string unaligned crossing: a0=0x102, mem[0x100]=0xXXXX4142, mem[0x104]=0x43000000 -> emits 'A','B','C'; reads 0x100 then 0x104.
- Backpressure: out_ready low 5 cycles per char, mem_ack delayed 3 cycles -> out_data/mem_addr stable while waiting; no duplicated or dropped chars.
- Exit and unknown code: v0=10 -> halted=1 and stall=1 persist until reset. v0=7 -> single sc_error pulse, no output, stall released.
- Reset mid-string (during STR_EMIT) and MAX_STR_LEN=4 with no null:
  - Reset: all outputs 0 immediately.
  - MAX_STR_LEN case: exactly 4 chars, then an sc_error pulse.
